// File: rtl/collision_detector_pkg.sv
// ---------------------------------------------------------------------------
// collision_detector_pkg
//   Shared definitions for the collision detector slice: default cooldown
//   length, cooldown FSM state type, counter widths and a saturating
//   increment helper used by the optional hit counter.
//
//   Optional feature macro used by importers: COLLISION_HIT_COUNT_EN
// ---------------------------------------------------------------------------
package collision_detector_pkg;

  localparam int unsigned COOLDOWN_FRAMES_DEFAULT = 4;
  localparam int unsigned CNT_W                   = 4;
  localparam int unsigned HIT_W                   = 8;

  typedef enum logic {
    ARMED,
    COOLDOWN
  } collision_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [HIT_W-1:0] sat_inc(input logic [HIT_W-1:0] v);
    if (v == {HIT_W{1'b1}}) begin
      return v;
    end
    return v + HIT_W'(1);
  endfunction

endpackage

// File: rtl/frame_cooldown.sv
// ---------------------------------------------------------------------------
// frame_cooldown
//   Two-state cooldown FSM with a 4-bit frame counter. After an obstacle
//   pulse it blocks obstacle latching for COOLDOWN_FRAMES unpaused frames.
//
//   Ports:
//     clk    in   system clock
//     reset  in   synchronous active-high reset
//     clear  in   level restart; same effect as reset
//     load   in   obstacle pulse being emitted at this frame boundary
//     tick   in   unpaused frame boundary
//     armed  out  registered: obstacle overlaps may be latched
// ---------------------------------------------------------------------------
module frame_cooldown
  import collision_detector_pkg::*;
#(
  parameter int unsigned COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic load,
  input  logic tick,
  output logic armed
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(COOLDOWN_FRAMES);

  collision_state_t   state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               armed_q, armed_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ARMED: begin
        // A zero-length cooldown never leaves ARMED.
        if (load && (LOAD_VAL != '0)) begin
          state_d = COOLDOWN;
          cnt_d   = LOAD_VAL;
        end
      end
      COOLDOWN: begin
        if (tick) begin
          if (cnt_q > CNT_W'(1)) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            cnt_d   = '0;
            state_d = ARMED;
          end
        end
      end
      default: begin
        state_d = ARMED;
        cnt_d   = '0;
      end
    endcase
    // Registered so the new state takes effect on the cycle after the boundary.
    armed_d = (state_d == ARMED);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q <= ARMED;
      cnt_q   <= '0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  assign armed = armed_q;

endmodule

// File: rtl/collision_detector.sv
// ---------------------------------------------------------------------------
// collision_detector
//   Latches ball/obstacle and ball/bottom overlaps over one video frame and
//   emits single-cycle registered collision pulses on the cycle after each
//   unpaused startOfFrame. Obstacle latching is gated by frame_cooldown.
//
//   Optional feature: define COLLISION_HIT_COUNT_EN to add hitCount[7:0],
//   a saturating count of collisionBallObstacle pulses.
//
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     startOfFrame               frame boundary pulse (no active pixel)
//     ballDR, obstacleGoodDR,
//     obstacleBadDR, bottomDR    per-pixel draw requests
//     pause                      game paused
//     reset_level_pulse          level restart, acts as reset
//     collisionBallObstacle      pulse: any obstacle hit last frame
//     collisionBallObstacleGood  pulse: good obstacle hit
//     collisionBallObstacleBad   pulse: bad obstacle hit
//     collisionBallBottom        pulse: bottom border hit
//     hitCount (optional)        saturating obstacle pulse count
// ---------------------------------------------------------------------------
module collision_detector
  import collision_detector_pkg::*;
#(
  parameter int unsigned COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic startOfFrame,
  input  logic ballDR,
  input  logic obstacleGoodDR,
  input  logic obstacleBadDR,
  input  logic bottomDR,
  input  logic pause,
  input  logic reset_level_pulse,
  output logic collisionBallObstacle,
  output logic collisionBallObstacleGood,
  output logic collisionBallObstacleBad,
  output logic collisionBallBottom
`ifdef COLLISION_HIT_COUNT_EN
  ,
  output logic [HIT_W-1:0] hitCount
`endif
);

  logic good_l_q, good_l_d;
  logic bad_l_q, bad_l_d;
  logic bottom_l_q, bottom_l_d;
  logic obs_q, obs_d;
  logic good_q, good_d;
  logic bad_q, bad_d;
  logic bottom_q, bottom_d;

  logic latch_en;
  logic frame_end;
  logic armed;
  logic cd_load;

  always_comb begin
    latch_en  = !startOfFrame && !pause && !reset_level_pulse;
    frame_end = startOfFrame && !pause && !reset_level_pulse;

    // Every boundary clears the latches, paused or not; a paused boundary
    // simply discards the frame.
    good_l_d   = good_l_q;
    bad_l_d    = bad_l_q;
    bottom_l_d = bottom_l_q;
    if (startOfFrame) begin
      good_l_d   = 1'b0;
      bad_l_d    = 1'b0;
      bottom_l_d = 1'b0;
    end else if (latch_en) begin
      if (armed) begin
        good_l_d = good_l_q | (ballDR & obstacleGoodDR);
        bad_l_d  = bad_l_q  | (ballDR & obstacleBadDR);
      end
      bottom_l_d = bottom_l_q | (ballDR & bottomDR);
    end

    obs_d    = frame_end & (good_l_q | bad_l_q);
    good_d   = frame_end & good_l_q;
    bad_d    = frame_end & bad_l_q;
    bottom_d = frame_end & bottom_l_q;

    cd_load  = obs_d;
  end

  always_ff @(posedge clk) begin
    if (reset || reset_level_pulse) begin
      good_l_q   <= 1'b0;
      bad_l_q    <= 1'b0;
      bottom_l_q <= 1'b0;
      obs_q      <= 1'b0;
      good_q     <= 1'b0;
      bad_q      <= 1'b0;
      bottom_q   <= 1'b0;
    end else begin
      good_l_q   <= good_l_d;
      bad_l_q    <= bad_l_d;
      bottom_l_q <= bottom_l_d;
      obs_q      <= obs_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      bottom_q   <= bottom_d;
    end
  end

  frame_cooldown #(
    .COOLDOWN_FRAMES(COOLDOWN_FRAMES)
  ) u_cooldown (
    .clk   (clk),
    .reset (reset),
    .clear (reset_level_pulse),
    .load  (cd_load),
    .tick  (frame_end),
    .armed (armed)
  );

  assign collisionBallObstacle     = obs_q;
  assign collisionBallObstacleGood = good_q;
  assign collisionBallObstacleBad  = bad_q;
  assign collisionBallBottom       = bottom_q;

`ifdef COLLISION_HIT_COUNT_EN
  logic [HIT_W-1:0] hit_count_q, hit_count_d;

  // Counts on the same edge the obstacle pulse is registered.
  always_comb begin
    hit_count_d = hit_count_q;
    if (obs_d) begin
      hit_count_d = sat_inc(hit_count_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || reset_level_pulse) begin
      hit_count_q <= '0;
    end else begin
      hit_count_q <= hit_count_d;
    end
  end

  assign hitCount = hit_count_q;
`endif

endmodule

// File: tb/tb_collision_detector.sv
// ---------------------------------------------------------------------------
// tb_collision_detector
//   Directed bench for collision_detector with the default cooldown of four
//   frames. Each frame is a run of pixel cycles followed by one startOfFrame
//   cycle; the expected pulse pattern after every boundary is hand-computed.
//   When COLLISION_HIT_COUNT_EN is defined the hitCount output is checked too.
// ---------------------------------------------------------------------------
module tb_collision_detector;

  logic clk;
  logic reset;
  logic startOfFrame;
  logic ballDR;
  logic obstacleGoodDR;
  logic obstacleBadDR;
  logic bottomDR;
  logic pause;
  logic reset_level_pulse;
  logic collisionBallObstacle;
  logic collisionBallObstacleGood;
  logic collisionBallObstacleBad;
  logic collisionBallBottom;
`ifdef COLLISION_HIT_COUNT_EN
  logic [7:0] hitCount;
`endif

  int passCount = 0;
  int totalCount = 0;

  collision_detector #(
    .COOLDOWN_FRAMES(4)
  ) dut (
    .clk                       (clk),
    .reset                     (reset),
    .startOfFrame              (startOfFrame),
    .ballDR                    (ballDR),
    .obstacleGoodDR            (obstacleGoodDR),
    .obstacleBadDR             (obstacleBadDR),
    .bottomDR                  (bottomDR),
    .pause                     (pause),
    .reset_level_pulse         (reset_level_pulse),
    .collisionBallObstacle     (collisionBallObstacle),
    .collisionBallObstacleGood (collisionBallObstacleGood),
    .collisionBallObstacleBad  (collisionBallObstacleBad),
    .collisionBallBottom       (collisionBallBottom)
`ifdef COLLISION_HIT_COUNT_EN
    ,
    .hitCount                  (hitCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, let the edge consume them, then settle 1ns
  // past the edge so outputs can be sampled away from it.
  task automatic applyStimulus(input logic sof, input logic ball,
                               input logic good, input logic bad,
                               input logic bottom, input logic pz,
                               input logic rlp);
    startOfFrame      = sof;
    ballDR            = ball;
    obstacleGoodDR    = good;
    obstacleBadDR     = bad;
    bottomDR          = bottom;
    pause             = pz;
    reset_level_pulse = rlp;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else begin
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Expected order: {Obstacle, Good, Bad, Bottom}
  task automatic checkPulse(input string tag, input logic [3:0] expected);
    checkOutput(tag, {4'b0000, collisionBallObstacle, collisionBallObstacleGood,
                      collisionBallObstacleBad, collisionBallBottom},
                {4'b0000, expected});
  endtask

  // One frame: npix pixel cycles, ball overlaps the selected drawers only on
  // pixel hitPix (other pixels show the drawers without the ball), then the
  // startOfFrame cycle.
  task automatic doFrame(input int npix, input int hitPix,
                         input logic hg, input logic hb, input logic hbot,
                         input logic pausePix, input logic pauseSof,
                         input logic rlpSof, input logic ballOnSof);
    for (int p = 0; p < npix; p++) begin
      applyStimulus(1'b0, (p == hitPix), hg, hb, hbot, pausePix, 1'b0);
    end
    applyStimulus(1'b1, ballOnSof, ballOnSof, ballOnSof, ballOnSof,
                  pauseSof, rlpSof);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    idleCycle();
    idleCycle();
    checkPulse("reset_outputs", 4'b0000);
`ifdef COLLISION_HIT_COUNT_EN
    checkOutput("reset_hitcount", hitCount, 8'd0);
`endif
    reset = 1'b0;
    idleCycle();

    // Frame 0: good hit on pixel 100.
    doFrame(120, 100, 1, 0, 0, 0, 0, 0, 0);
    checkPulse("f0_good_pulse", 4'b1100);
    idleCycle();
    checkPulse("f0_pulse_one_cycle", 4'b0000);

    // Frames 1-4: repeated good hits swallowed by the cooldown.
    doFrame(8, 3, 1, 0, 0, 0, 0, 0, 0);
    checkPulse("f1_cooldown", 4'b0000);
    doFrame(8, 3, 1, 0, 0, 0, 0, 0, 0);
    checkPulse("f2_cooldown", 4'b0000);
    doFrame(8, 3, 1, 0, 0, 0, 0, 0, 0);
    checkPulse("f3_cooldown", 4'b0000);
    doFrame(8, 3, 1, 0, 0, 0, 0, 0, 0);
    checkPulse("f4_cooldown", 4'b0000);

    // Frame 5: armed again.
    doFrame(8, 3, 1, 0, 0, 0, 0, 0, 0);
    checkPulse("f5_rearmed", 4'b1100);

    // Frame 6: in cooldown, bottom still latches, good ignored. Counter 4->3.
    doFrame(8, 2, 1, 0, 1, 0, 0, 0, 0);
    checkPulse("f6_bottom_in_cooldown", 4'b0001);
    doFrame(8, 2, 0, 0, 0, 0, 0, 0, 0);
    checkPulse("f7_empty", 4'b0000);
    doFrame(8, 2, 0, 0, 0, 0, 0, 0, 0);
    checkPulse("f8_empty", 4'b0000);

    // Counter is now 1. Two paused frames must leave it there.
    doFrame(8, 2, 0, 0, 1, 1, 1, 0, 0);
    checkPulse("f9_paused_frame", 4'b0000);
    doFrame(8, 2, 0, 0, 1, 0, 1, 0, 0);
    checkPulse("f10_paused_boundary", 4'b0000);
    doFrame(8, 2, 1, 0, 0, 0, 0, 0, 0);
    checkPulse("f11_still_cooldown", 4'b0000);

    // Frame 12: armed; good, bad and bottom in one frame.
    doFrame(8, 4, 1, 1, 1, 0, 0, 0, 0);
    checkPulse("f12_all_four", 4'b1111);
    idleCycle();
    checkPulse("f12_pulse_one_cycle", 4'b0000);
`ifdef COLLISION_HIT_COUNT_EN
    checkOutput("hitcount_three", hitCount, 8'd3);
`endif

    // Frame 13: overlap only on the startOfFrame cycle is ignored.
    doFrame(8, 99, 0, 0, 0, 0, 0, 0, 1);
    checkPulse("f13_ball_on_sof", 4'b0000);
    doFrame(8, 99, 0, 0, 0, 0, 0, 0, 0);
    checkPulse("f14_no_leak", 4'b0000);

    // Frame 15: bottom latched, level restart coincides with startOfFrame.
    doFrame(8, 2, 1, 0, 1, 0, 0, 1, 0);
    checkPulse("f15_rlp_suppresses", 4'b0000);
`ifdef COLLISION_HIT_COUNT_EN
    checkOutput("hitcount_rlp_clear", hitCount, 8'd0);
`endif

    // Frame 16: restart left the FSM armed with counter 0.
    doFrame(8, 2, 0, 1, 0, 0, 0, 0, 0);
    checkPulse("f16_armed_after_rlp", 4'b1010);

`ifdef COLLISION_HIT_COUNT_EN
    checkOutput("hitcount_one", hitCount, 8'd1);
    // Let the cooldown from frame 16 expire, then 300 spaced hits.
    for (int k = 0; k < 4; k++) begin
      doFrame(3, 1, 0, 0, 0, 0, 0, 0, 0);
    end
    for (int h = 0; h < 300; h++) begin
      doFrame(3, 1, 1, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
        doFrame(3, 1, 0, 0, 0, 0, 0, 0, 0);
      end
    end
    checkOutput("hitcount_saturated", hitCount, 8'd255);
`endif

    $display("[TB] %0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
